// File: rtl/vx_dispatch_arb.sv
// vx_dispatch_arb: shares one execution unit between NUM_REQS dispatch streams.
// Round-robin arbitration with the grant locked for a whole packet. Each packet
// is serialised into NUM_THREADS/NUM_LANES lane-beats, and beats whose lane mask
// is empty are skipped. A single output register stage drives the execute unit.

// Per-lane operand/mask select out of the currently active batch.
module vx_dispatch_arb_lane #(
    parameter int BATCHES   = 2,
    parameter int NUM_LANES = 2,
    parameter int LANEW     = 96,
    parameter int PID_W     = 1,
    parameter int LANE      = 0
) (
    input  logic [PID_W-1:0]                         pid,
    input  logic [BATCHES*NUM_LANES-1:0]             tmask,
    input  logic [BATCHES*NUM_LANES-1:0][LANEW-1:0]  data,
    output logic                                     lane_tmask,
    output logic [LANEW-1:0]                         lane_data
);

    // Mux thread (pid*NUM_LANES + LANE) onto this lane
    always_comb begin
        lane_tmask = 1'b0;
        lane_data  = '0;
        for (int b = 0; b < BATCHES; b++) begin
            if (pid == PID_W'(b)) begin
                lane_tmask = tmask[b*NUM_LANES + LANE];
                lane_data  = data[b*NUM_LANES + LANE];
            end
        end
    end

endmodule

module vx_dispatch_arb #(
    parameter int NUM_REQS    = 4,
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 2,
    parameter int HDRW        = 64,
    parameter int LANEW       = 96,
    localparam int BATCHES    = NUM_THREADS / NUM_LANES,
    localparam int PID_W      = (BATCHES > 1) ? $clog2(BATCHES) : 1,
    localparam int RIDX_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_REQS-1:0]                           req_valid,
    output logic [NUM_REQS-1:0]                           req_ready,
    input  logic [NUM_REQS-1:0][HDRW-1:0]                 req_hdr,
    input  logic [NUM_REQS-1:0][NUM_THREADS-1:0]          req_tmask,
    input  logic [NUM_REQS-1:0][NUM_THREADS-1:0][LANEW-1:0] req_data,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [HDRW-1:0]                               out_hdr,
    output logic [NUM_LANES-1:0]                          out_tmask,
    output logic [NUM_LANES-1:0][LANEW-1:0]               out_data,
    output logic [PID_W-1:0]                              out_pid,
    output logic                                          out_sop,
    output logic                                          out_eop,
    output logic [RIDX_W-1:0]                             out_ridx
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    typedef struct packed {
        logic [HDRW-1:0]                 hdr;
        logic [NUM_LANES-1:0]            tmask;
        logic [NUM_LANES-1:0][LANEW-1:0] data;
        logic [PID_W-1:0]                pid;
        logic                            sop;
        logic                            eop;
        logic [RIDX_W-1:0]               ridx;
    } beat_t;

    state_t                               state, state_n;
    logic [RIDX_W-1:0]                    rr_ptr, ptr_next;
    logic                                 out_valid_q;
    beat_t                                out_q, beat_d;

    logic                                 arb_found;
    logic [RIDX_W-1:0]                    arb_idx;
    logic [RIDX_W-1:0]                    sel_idx;
    logic [HDRW-1:0]                      sel_hdr;
    logic [NUM_THREADS-1:0]               sel_tmask;
    logic [NUM_THREADS-1:0][LANEW-1:0]    sel_data;
    logic [BATCHES-1:0]                   batch_nz;
    logic [PID_W-1:0]                     beat_pid;
    logic                                 beat_eop;
    logic [NUM_LANES-1:0]                 beat_tmask;
    logic [NUM_LANES-1:0][LANEW-1:0]      beat_data;
    logic                                 can_load;
    logic                                 fire;

    assign can_load = !out_valid_q || out_ready;
    // In BUSY the locked grant is simply the ridx of the beat already loaded.
    assign sel_idx  = (state == BUSY) ? out_q.ridx : arb_idx;
    assign fire     = can_load && ((state == BUSY) || arb_found);
    assign ptr_next = (arb_idx == RIDX_W'(NUM_REQS-1)) ? '0 : arb_idx + RIDX_W'(1);

    // Round-robin pick: first valid requester at or after the pointer, wrapping
    always_comb begin
        int k;
        arb_found = 1'b0;
        arb_idx   = '0;
        k         = 0;
        for (int i = 0; i < NUM_REQS; i++) begin
            k = (int'(rr_ptr) + i) % NUM_REQS;
            if (!arb_found && req_valid[k]) begin
                arb_found = 1'b1;
                arb_idx   = RIDX_W'(k);
            end
        end
    end

    // Route the selected requester's packet into the beat builder
    always_comb begin
        sel_hdr   = '0;
        sel_tmask = '0;
        sel_data  = '0;
        for (int r = 0; r < NUM_REQS; r++) begin
            if (sel_idx == RIDX_W'(r)) begin
                sel_hdr   = req_hdr[r];
                sel_tmask = req_tmask[r];
                sel_data  = req_data[r];
            end
        end
    end

    // Per-batch non-empty flags
    always_comb begin
        batch_nz = '0;
        for (int b = 0; b < BATCHES; b++)
            batch_nz[b] = |sel_tmask[b*NUM_LANES +: NUM_LANES];
    end

    // Next non-empty batch after the last emitted one (from 0 on a new packet);
    // eop when nothing non-empty remains above it. An all-zero packet falls
    // through to pid 0 with eop set, giving its single empty beat.
    always_comb begin
        int  start;
        logic found;
        start    = (state == BUSY) ? int'(out_q.pid) + 1 : 0;
        found    = 1'b0;
        beat_pid = '0;
        beat_eop = 1'b1;
        for (int b = 0; b < BATCHES; b++) begin
            if (b >= start && batch_nz[b]) begin
                if (!found) begin
                    found    = 1'b1;
                    beat_pid = PID_W'(b);
                end else begin
                    beat_eop = 1'b0;
                end
            end
        end
    end

    // Lane slice select, one instance per execution lane
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        vx_dispatch_arb_lane #(
            .BATCHES   (BATCHES),
            .NUM_LANES (NUM_LANES),
            .LANEW     (LANEW),
            .PID_W     (PID_W),
            .LANE      (l)
        ) u_lane (
            .pid        (beat_pid),
            .tmask      (sel_tmask),
            .data       (sel_data),
            .lane_tmask (beat_tmask[l]),
            .lane_data  (beat_data[l])
        );
    end

    // Assemble the beat that loads on fire
    always_comb begin
        beat_d       = '0;
        beat_d.hdr   = sel_hdr;
        beat_d.tmask = beat_tmask;
        beat_d.data  = beat_data;
        beat_d.pid   = beat_pid;
        beat_d.sop   = (state == IDLE);
        beat_d.eop   = beat_eop;
        beat_d.ridx  = sel_idx;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // FSM next state: enter BUSY after a non-final first beat, leave on eop load
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (fire && !beat_eop) state_n = BUSY;
            BUSY: if (fire &&  beat_eop) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM outputs: ack the granted requester only as its eop beat loads
    always_comb begin
        req_ready = '0;
        for (int r = 0; r < NUM_REQS; r++)
            req_ready[r] = !reset && fire && beat_eop && (sel_idx == RIDX_W'(r));
    end

    // Output stage and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            if (fire && state == IDLE)
                rr_ptr <= ptr_next;
            if (can_load) begin
                out_valid_q <= fire;
                if (fire)
                    out_q <= beat_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_hdr   = out_q.hdr;
    assign out_tmask = out_q.tmask;
    assign out_data  = out_q.data;
    assign out_pid   = out_q.pid;
    assign out_sop   = out_q.sop;
    assign out_eop   = out_q.eop;
    assign out_ridx  = out_q.ridx;

    // A granted requester must keep valid up until its packet is acked
    a_grant_held: assert property (@(posedge clk) disable iff (reset)
        (state == BUSY) |-> req_valid[out_q.ridx]);

endmodule

// File: tb/tb_vx_dispatch_arb.sv
// Directed bench for vx_dispatch_arb: a vector table for single-packet beat
// splitting, plus sequences for round-robin, back-pressure, mid-packet reset
// and a single-beat (NUM_LANES == NUM_THREADS) configuration.
module tb_vx_dispatch_arb;

    localparam int NR = 4;
    localparam int NT = 4;
    localparam int HW = 64;
    localparam int LW = 96;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT a: 2 lanes
    logic [NR-1:0]                 req_valid, req_ready;
    logic [NR-1:0][HW-1:0]         req_hdr;
    logic [NR-1:0][NT-1:0]         req_tmask;
    logic [NR-1:0][NT-1:0][LW-1:0] req_data;
    logic                          out_valid, out_ready;
    logic [HW-1:0]                 out_hdr;
    logic [1:0]                    out_tmask;
    logic [1:0][LW-1:0]            out_data;
    logic [0:0]                    out_pid;
    logic                          out_sop, out_eop;
    logic [1:0]                    out_ridx;

    // DUT b: 4 lanes, single-beat packets
    logic [NR-1:0]                 b_req_valid, b_req_ready;
    logic [NR-1:0][HW-1:0]         b_req_hdr;
    logic [NR-1:0][NT-1:0]         b_req_tmask;
    logic [NR-1:0][NT-1:0][LW-1:0] b_req_data;
    logic                          b_out_valid;
    logic [HW-1:0]                 b_out_hdr;
    logic [3:0]                    b_out_tmask;
    logic [3:0][LW-1:0]            b_out_data;
    logic [0:0]                    b_out_pid;
    logic                          b_out_sop, b_out_eop;
    logic [1:0]                    b_out_ridx;

    vx_dispatch_arb #(.NUM_REQS(NR), .NUM_THREADS(NT), .NUM_LANES(2), .HDRW(HW), .LANEW(LW)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_hdr(req_hdr),
        .req_tmask(req_tmask), .req_data(req_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_hdr(out_hdr),
        .out_tmask(out_tmask), .out_data(out_data), .out_pid(out_pid),
        .out_sop(out_sop), .out_eop(out_eop), .out_ridx(out_ridx)
    );

    vx_dispatch_arb #(.NUM_REQS(NR), .NUM_THREADS(NT), .NUM_LANES(4), .HDRW(HW), .LANEW(LW)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_hdr(b_req_hdr),
        .req_tmask(b_req_tmask), .req_data(b_req_data),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_hdr(b_out_hdr),
        .out_tmask(b_out_tmask), .out_data(b_out_data), .out_pid(b_out_pid),
        .out_sop(b_out_sop), .out_eop(b_out_eop), .out_ridx(b_out_ridx)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] tmask;
        int         nb;
        int         pid0;
        logic [1:0] tm0;
        int         pid1;
        logic [1:0] tm1;
    } vec_t;

    vec_t vt[7];

    function automatic logic [LW-1:0] tdata(input int r, input int t);
        return {32'(r), 32'(t), 32'hA5A5_0000 + 32'(r*16 + t)};
    endfunction

    function automatic logic [HW-1:0] hdr_of(input int r);
        return {32'h1234_0000 + 32'(r), 32'hCAFE_0000 + 32'(r)};
    endfunction

    task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int r, input int p,
                            input logic [1:0] tm, input logic sop, input logic eop);
        chk({tag, ".valid"}, 384'(out_valid), 384'(1'b1));
        chk({tag, ".ridx"},  384'(out_ridx),  384'(r));
        chk({tag, ".pid"},   384'(out_pid),   384'(p));
        chk({tag, ".tmask"}, 384'(out_tmask), 384'(tm));
        chk({tag, ".sop"},   384'(out_sop),   384'(sop));
        chk({tag, ".eop"},   384'(out_eop),   384'(eop));
        chk({tag, ".hdr"},   384'(out_hdr),   384'(hdr_of(r)));
        chk({tag, ".data"},  384'(out_data),  384'({tdata(r, 2*p+1), tdata(r, 2*p)}));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        vt[0] = '{4'b1111, 2, 0, 2'b11, 1, 2'b11};
        vt[1] = '{4'b1100, 1, 1, 2'b11, 0, 2'b00};
        vt[2] = '{4'b0000, 1, 0, 2'b00, 0, 2'b00};
        vt[3] = '{4'b0011, 1, 0, 2'b11, 0, 2'b00};
        vt[4] = '{4'b0110, 2, 0, 2'b10, 1, 2'b01};
        vt[5] = '{4'b1001, 2, 0, 2'b01, 1, 2'b10};
        vt[6] = '{4'b0100, 1, 1, 2'b01, 0, 2'b00};

        for (int r = 0; r < NR; r++) begin
            req_hdr[r]     = hdr_of(r);
            b_req_hdr[r]   = hdr_of(r);
            req_tmask[r]   = 4'hF;
            b_req_tmask[r] = 4'hF;
            for (int t = 0; t < NT; t++) begin
                req_data[r][t]   = tdata(r, t);
                b_req_data[r][t] = tdata(r, t);
            end
        end
        reset       = 1'b1;
        out_ready   = 1'b1;
        req_valid   = '0;
        b_req_valid = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state
        chk("rst.valid", 384'(out_valid), 384'(0));
        chk("rst.ready", 384'(req_ready), 384'(0));
        chk("rst.hdr",   384'(out_hdr),   384'(0));
        chk("rst.tmask", 384'(out_tmask), 384'(0));
        chk("rst.pid",   384'(out_pid),   384'(0));
        chk("rst.sop",   384'(out_sop),   384'(0));
        chk("rst.eop",   384'(out_eop),   384'(0));
        chk("rst.ridx",  384'(out_ridx),  384'(0));
        chk("rst.b_valid", 384'(b_out_valid), 384'(0));

        // Vector table: one packet from req0, beats checked one cycle apart
        for (int v = 0; v < 7; v++) begin
            req_tmask[0] = vt[v].tmask;
            req_valid    = 4'b0001;
            #1;
            chk("vec.rdy_first", 384'(req_ready), 384'((vt[v].nb == 1) ? 4'b0001 : 4'b0000));
            @(negedge clk);
            chk_beat("vec.b0", 0, vt[v].pid0, vt[v].tm0, 1'b1, vt[v].nb == 1);
            if (vt[v].nb == 2) begin
                chk("vec.rdy_eop", 384'(req_ready), 384'(4'b0001));
                @(negedge clk);
                chk_beat("vec.b1", 0, vt[v].pid1, vt[v].tm1, 1'b0, 1'b1);
            end
            req_valid = '0;
            #1;
            chk("vec.rdy_idle", 384'(req_ready), 384'(0));
            @(negedge clk);
            chk("vec.gap", 384'(out_valid), 384'(0));
        end
        req_tmask[0] = 4'hF;

        // Round-robin with all requesters valid
        do_reset();
        req_valid = 4'b1111;
        #1;
        chk("rr.rdy_first", 384'(req_ready), 384'(0));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk_beat("rr", (k/2) % 4, k % 2, 2'b11, (k % 2) == 0, (k % 2) == 1);
            chk("rr.rdy", 384'(req_ready), 384'(((k+1) % 2 == 1) ? (4'b0001 << (((k+1)/2) % 4)) : 4'b0000));
        end
        req_valid = '0;
        @(negedge clk);
        chk("rr.end", 384'(out_valid), 384'(0));

        // Back-pressure mid-packet, req2 arrives during the locked packet
        do_reset();
        req_valid = 4'b0001;
        @(negedge clk);
        chk_beat("bp.b0", 0, 0, 2'b11, 1'b1, 1'b0);
        out_ready    = 1'b0;
        req_valid[2] = 1'b1;
        #1;
        chk("bp.rdy_stall", 384'(req_ready), 384'(0));
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            chk_beat("bp.hold", 0, 0, 2'b11, 1'b1, 1'b0);
            chk("bp.rdy_hold", 384'(req_ready), 384'(0));
        end
        out_ready = 1'b1;
        #1;
        chk("bp.rdy_eop", 384'(req_ready), 384'(4'b0001));
        @(negedge clk);
        chk_beat("bp.b1", 0, 1, 2'b11, 1'b0, 1'b1);
        req_valid[0] = 1'b0;
        #1;
        chk("bp.rdy_r2b0", 384'(req_ready), 384'(0));
        @(negedge clk);
        chk_beat("bp.r2b0", 2, 0, 2'b11, 1'b1, 1'b0);
        chk("bp.rdy_r2eop", 384'(req_ready), 384'(4'b0100));
        @(negedge clk);
        chk_beat("bp.r2b1", 2, 1, 2'b11, 1'b0, 1'b1);
        req_valid = '0;
        @(negedge clk);
        chk("bp.end", 384'(out_valid), 384'(0));

        // Reset during req1's first beat; req3 also waiting
        do_reset();
        req_valid = 4'b1010;
        @(negedge clk);
        chk_beat("rs.b0", 1, 0, 2'b11, 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rs.valid", 384'(out_valid), 384'(0));
        chk("rs.ready", 384'(req_ready), 384'(0));
        reset = 1'b0;
        @(negedge clk);
        chk_beat("rs.re0", 1, 0, 2'b11, 1'b1, 1'b0);
        @(negedge clk);
        chk_beat("rs.re1", 1, 1, 2'b11, 1'b0, 1'b1);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk_beat("rs.r3b0", 3, 0, 2'b11, 1'b1, 1'b0);
        @(negedge clk);
        chk_beat("rs.r3b1", 3, 1, 2'b11, 1'b0, 1'b1);
        req_valid = '0;
        @(negedge clk);
        chk("rs.end", 384'(out_valid), 384'(0));

        // Four-lane config: single-beat packets, ack in the load cycle
        b_req_tmask[0] = 4'b1010;
        b_req_tmask[3] = 4'b0000;
        b_req_valid    = 4'b1001;
        #1;
        chk("b.rdy0", 384'(b_req_ready), 384'(4'b0001));
        @(negedge clk);
        chk("b.r0.valid", 384'(b_out_valid), 384'(1));
        chk("b.r0.ridx",  384'(b_out_ridx),  384'(0));
        chk("b.r0.pid",   384'(b_out_pid),   384'(0));
        chk("b.r0.tmask", 384'(b_out_tmask), 384'(4'b1010));
        chk("b.r0.sop",   384'(b_out_sop),   384'(1));
        chk("b.r0.eop",   384'(b_out_eop),   384'(1));
        chk("b.r0.hdr",   384'(b_out_hdr),   384'(hdr_of(0)));
        chk("b.r0.data",  384'(b_out_data),  {tdata(0,3), tdata(0,2), tdata(0,1), tdata(0,0)});
        b_req_valid[0] = 1'b0;
        #1;
        chk("b.rdy3", 384'(b_req_ready), 384'(4'b1000));
        @(negedge clk);
        chk("b.r3.valid", 384'(b_out_valid), 384'(1));
        chk("b.r3.ridx",  384'(b_out_ridx),  384'(3));
        chk("b.r3.tmask", 384'(b_out_tmask), 384'(0));
        chk("b.r3.sop",   384'(b_out_sop),   384'(1));
        chk("b.r3.eop",   384'(b_out_eop),   384'(1));
        chk("b.r3.data",  384'(b_out_data),  {tdata(3,3), tdata(3,2), tdata(3,1), tdata(3,0)});
        b_req_valid = '0;
        @(negedge clk);
        chk("b.end", 384'(b_out_valid), 384'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vx_dispatch_arb.md
Name: vx_dispatch_arb

Overview:
- Shares one execution unit between NUM_REQS dispatch streams, e.g. the per-issue-slice dispatch buffers feeding a single ALU/LSU/SFU instance.
- Arbitrates round-robin and locks the grant for the whole packet.
- Serialises each granted packet into NUM_THREADS/NUM_LANES lane-beats, skipping beats whose lane mask is empty.
- Sits between the dispatch buffers and the execute-unit input.

Parameters:
NUM_REQS, 4, number of requesting dispatch streams (>=1)
NUM_THREADS, 4, threads per request packet
NUM_LANES, 2, lanes of the execution unit; must divide NUM_THREADS
HDRW, 64, per-packet header width (uuid, wis, PC, op, rd, wb, ...)
LANEW, 96, per-thread operand width (rs1/rs2/rs3 data)
Derived: BATCHES = NUM_THREADS/NUM_LANES; PID_W = max(1, clog2(BATCHES)); RIDX_W = max(1, clog2(NUM_REQS))

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQS  per-requester valid
req_ready  out  NUM_REQS  per-requester ready; the packet is consumed when valid&ready
req_hdr  in  NUM_REQS*HDRW  packet headers
req_tmask  in  NUM_REQS*NUM_THREADS  thread masks
req_data  in  NUM_REQS*NUM_THREADS*LANEW  per-thread operands
out_valid  out  1  beat valid
out_ready  in  1  execution unit accepts beat
out_hdr  out  HDRW  header of current packet
out_tmask  out  NUM_LANES  lane mask slice for this beat
out_data  out  NUM_LANES*LANEW  operand slice for this beat
out_pid  out  PID_W  batch index of this beat
out_sop  out  1  first emitted beat of packet
out_eop  out  1  last emitted beat of packet
out_ridx  out  RIDX_W  index of granted requester

Behaviour:

Reset:
- out_valid=0, req_ready=0, state=IDLE.
- RR pointer=0 (requester 0 has highest priority first).
- All other out_* regs = 0.
- Reset mid-packet aborts it; the requester is not acked and its packet is retried after reset.

Output register:
- A single stage loads when (!out_valid || out_ready).
- Latency from req_valid (output empty, IDLE) to out_valid is 1 cycle.
- Throughput is 1 beat/cycle while out_ready=1.

FSM IDLE:
- If any req_valid, pick the first valid index starting at the RR pointer, cyclically.
- If the output stage can load: latch the grant, load the first non-empty batch, set sop=1.
- Go to BUSY, or stay IDLE if that beat is also eop.
- Pointer := grant+1 mod NUM_REQS, updated when the grant is taken.

FSM BUSY:
- Grant is locked. Arbitration is frozen and other requesters are not considered.
- On each load opportunity, emit the next non-empty batch after the last pid.
- Return to IDLE after loading the eop beat.

Beat selection:
- Batch b covers threads [b*NUM_LANES, (b+1)*NUM_LANES).
- A batch is skipped if its tmask slice is 0.
- eop=1 when no higher batch has a non-zero slice.
- A packet with tmask==0 emits one beat: pid=0, tmask=0, sop=eop=1.

Acknowledge:
- req_ready[g] is asserted combinationally only in the cycle the eop beat of grant g loads into the output register.
- All other req_ready bits are 0 in that cycle.
- Requesters hold hdr/tmask/data stable while valid and not yet acked; this is a protocol requirement, not checked.

Back-to-back and degenerate cases:
- The next packet (new arbitration) can load in the cycle right after the eop load. There are no bubbles between packets.
- If NUM_LANES==NUM_THREADS: every packet is a single beat with sop=eop=1, and BUSY is never entered.
- NUM_REQS==1: the arbiter degenerates to pass-through; out_ridx=0.

Simultaneous events:
- out_ready=0 holds all out_* stable and freezes the FSM.
- A requester deasserting valid while granted is illegal; behaviour is undefined, assertion in sim.

Test Plan:
- Reset, single req0 with tmask=4'b1111 (NUM_LANES=2): beats pid0 (sop=1, tmask 2'b11) then pid1 (eop=1); req_ready[0] pulses with the second beat load; out_valid goes high the cycle after req_valid.
- req0 tmask=4'b1100: exactly one beat, pid=1, sop=eop=1, tmask=2'b11, data = threads 2,3. tmask=4'b0000: one beat, pid=0, tmask=0.
- All 4 requesters valid continuously, full masks, out_ready=1: grant order 0,1,2,3,0, two beats each, no gaps; each req_ready pulses once per packet.
- Back-pressure: out_ready low for 3 cycles mid-packet; all out_* fields stay stable; no beat is duplicated or lost; req2 asserting valid mid-packet does not break the lock.
- Reset asserted during pid0 of req1's packet: out_valid=0 the next cycle; after release, req1 is re-granted from the RR pointer (=0) and the packet is re-sent from pid0.
- NUM_LANES=NUM_THREADS=4 config: every accepted packet is one beat with sop=eop=1; req_ready pulses in the same cycle the beat loads.
